// File: rtl/mdd_pkg.sv
// mdd_pkg
//  Shared encodings for the multi-cycle arithmetic unit.
//  - op_e   : operation codes as presented on the op port
//  - state_e: sequencer states of mdd_seq_unit
package mdd_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdd_iter_core.sv
// mdd_iter_core
//  Iteration datapath shared by MUL (shift-add) and DIV (restoring).
//  Holds the 2*WIDTH shift register {upper, lower} and one WIDTH+1 bit
//  adder/subtractor. load seeds the register with {0, a}; each step performs
//  one MUL or DIV iteration. acc_next is the value the register takes on the
//  next step, so the caller can capture the final result on the last step.
// Ports
//  clk      in   1        clock, rising edge
//  rst_n    in   1        synchronous reset, active-low
//  load     in   1        seed register with {0, a_in}
//  step     in   1        perform one iteration
//  is_div   in   1        1 = restoring divide step, 0 = shift-add multiply step
//  a_in     in   WIDTH    multiplier / dividend (used on load)
//  b_in     in   WIDTH    multiplicand / divisor (held stable while stepping)
//  acc_next out  2*WIDTH  register value after the current step
module mdd_iter_core #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     lhs, addend;
  logic [WIDTH+1:0]   as_full;
  logic               ge;
  logic [WIDTH-1:0]   rem_new;

  // DIV shifts the next dividend bit into the partial remainder before comparing.
  assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};

  // One adder serves both ops: MUL adds b (or 0) to the upper half,
  // DIV computes rem_sh - b as rem_sh + ~b + 1, whose carry-out means rem_sh >= b.
  assign lhs     = is_div ? rem_sh : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign addend  = is_div ? ~{1'b0, b_in}
                          : (acc_q[0] ? {1'b0, b_in} : '0);
  assign as_full = {1'b0, lhs} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, is_div};
  assign ge      = as_full[WIDTH+1];
  assign rem_new = ge ? as_full[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  always_comb begin
    if (is_div) begin
      acc_next = {rem_new, acc_q[WIDTH-2:0], ge};
    end else begin
      acc_next = {as_full[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, a_in};
    end else if (step) begin
      acc_d = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mdd_seq_unit.sv
// mdd_seq_unit
//  Multi-cycle unsigned ADD/SUB/MUL/DIV with a start/done handshake.
//  ADD, SUB and divide-by-zero complete in one cycle; MUL and DIV iterate
//  one bit per clock in mdd_iter_core and complete after WIDTH+1 cycles.
// Ports
//  clk     in   1      clock, rising edge
//  rst_n   in   1      synchronous reset, active-low
//  start   in   1      request, sampled only in IDLE
//  op      in   2      0=ADD 1=SUB 2=MUL 3=DIV, sampled with start
//  a, b    in   WIDTH  unsigned operands, sampled with start
//  busy    out  1      high in RUN and DONE
//  done    out  1      one-cycle completion pulse
//  result  out  WIDTH  sum/difference, MUL low half, DIV quotient
//  hi      out  WIDTH  carry/borrow in bit0, MUL high half, DIV remainder
//  dz      out  1      divide-by-zero, valid with done
module mdd_seq_unit
  import mdd_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dz_q, dz_d;

  logic               core_load, core_step;
  logic [2*WIDTH-1:0] core_acc_next;
  logic [WIDTH:0]     add_sum, sub_diff;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the extended difference is the borrow, i.e. a < b.
  assign sub_diff = {1'b0, a} - {1'b0, b};

  mdd_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (core_step),
    .is_div   (op_q == OP_DIV),
    .a_in     (a),
    .b_in     (b_q),
    .acc_next (core_acc_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    result_d  = result_q;
    hi_d      = hi_q;
    dz_d      = dz_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op_e'(op);
          b_d  = b;
          case (op_e'(op))
            OP_ADD: begin
              result_d = add_sum[WIDTH-1:0];
              hi_d     = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
              dz_d     = 1'b0;
              state_d  = S_DONE;
            end
            OP_SUB: begin
              result_d = sub_diff[WIDTH-1:0];
              hi_d     = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
              dz_d     = 1'b0;
              state_d  = S_DONE;
            end
            default: begin
              if (op_e'(op) == OP_DIV && b == '0) begin
                result_d = '1;
                hi_d     = a;
                dz_d     = 1'b1;
                state_d  = S_DONE;
              end else begin
                core_load = 1'b1;
                cnt_d     = '0;
                state_d   = S_RUN;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        // The last of WIDTH iterations: capture the core's final value directly.
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          {hi_d, result_d} = core_acc_next;
          dz_d             = 1'b0;
          state_d          = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      b_q      <= '0;
      result_q <= '0;
      hi_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      dz_q     <= dz_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign hi     = hi_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_mdd_seq_unit.sv
// tb_mdd_seq_unit
//  Table-driven vectors plus hand-written multi-cycle sequences (start held
//  high through a MUL, reset in the middle of a DIV). Expected results are
//  pushed to a scoreboard queue when an op is issued and popped on done.
module tb_mdd_seq_unit;

  localparam int WIDTH = 6;
  localparam int NVEC  = 14;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic             dz;
    int               lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, dz;
  logic [WIDTH-1:0] result, hi;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl [NVEC];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  mdd_seq_unit #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .dz     (dz)
  );

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
    vec_t v;
    int   p;
    v.op = o; v.a = x; v.b = y; v.dz = 1'b0; v.lat = 1;
    case (o)
      2'd0: begin p = int'(x) + int'(y); v.res = WIDTH'(p); v.hi = WIDTH'(p >> WIDTH); end
      2'd1: begin p = int'(x) - int'(y); v.res = WIDTH'(p); v.hi = (x < y) ? 1 : 0; end
      2'd2: begin p = int'(x) * int'(y); v.res = WIDTH'(p); v.hi = WIDTH'(p >> WIDTH); v.lat = WIDTH + 1; end
      default: begin
        if (y == 0) begin v.res = '1; v.hi = x; v.dz = 1'b1; end
        else begin v.res = x / y; v.hi = x % y; v.lat = WIDTH + 1; end
      end
    endcase
    return v;
  endfunction

  // Wait (bounded) for done, counting cycles from the start-sampling edge.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic compare_done(input string name, input int lat);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: done with empty scoreboard", name);
      return;
    end
    e = exp_q.pop_front();
    $display("op=%0d a=%0d b=%0d -> result=%0d hi=%0d dz=%0d lat=%0d",
             e.op, e.a, e.b, result, hi, dz, lat);
    check({name, " lat"}, lat, e.lat);
    check({name, " result"}, int'(result), int'(e.res));
    check({name, " hi"}, int'(hi), int'(e.hi));
    check({name, " dz"}, int'(dz), int'(e.dz));
  endtask

  task automatic do_op(input string name, input vec_t v);
    int lat;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    exp_q.push_back(v);
    wait_done(lat);
    compare_done(name, lat);
    @(negedge clk);
    check({name, " done pulse width"}, int'(done), 0);
    check({name, " busy after"}, int'(busy), 0);
  endtask

  task automatic set_v(input int i, input logic [1:0] o, input int x, input int y,
                       input int r, input int h, input int z, input int l);
    tbl[i].op = o; tbl[i].a = WIDTH'(x); tbl[i].b = WIDTH'(y);
    tbl[i].res = WIDTH'(r); tbl[i].hi = WIDTH'(h); tbl[i].dz = z[0]; tbl[i].lat = l;
  endtask

  initial begin
    int   lat;
    vec_t v;
    logic seen;

    set_v(0,  2'd2, 15, 24, 40, 5,  0, 7);
    set_v(1,  2'd3, 18, 5,  3,  3,  0, 7);
    set_v(2,  2'd3, 3,  8,  0,  3,  0, 7);
    set_v(3,  2'd0, 40, 31, 7,  1,  0, 1);
    set_v(4,  2'd1, 3,  5,  62, 1,  0, 1);
    set_v(5,  2'd1, 15, 8,  7,  0,  0, 1);
    set_v(6,  2'd3, 7,  0,  63, 7,  1, 1);
    set_v(7,  2'd0, 1,  1,  2,  0,  0, 1);
    set_v(8,  2'd2, 0,  45, 0,  0,  0, 7);
    set_v(9,  2'd2, 63, 63, 1,  62, 0, 7);
    set_v(10, 2'd3, 63, 1,  63, 0,  0, 7);
    set_v(11, 2'd3, 0,  9,  0,  0,  0, 7);
    set_v(12, 2'd0, 63, 63, 62, 1,  0, 1);
    set_v(13, 2'd2, 37, 0,  0,  0,  0, 7);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset hi", int'(hi), 0);
    check("reset dz", int'(dz), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Random ops against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      v = model(2'($urandom_range(3)), WIDTH'($urandom), WIDTH'($urandom));
      do_op($sformatf("rnd%0d", i), v);
    end

    // MUL 63*63 with start held high and operands changed mid-RUN
    @(negedge clk);
    op = 2'd2; a = 6'd63; b = 6'd63; start = 1'b1;
    exp_q.push_back(model(2'd2, 6'd63, 6'd63));
    @(negedge clk);
    op = 2'd0; a = 6'd1; b = 6'd1;           // start stays high
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    compare_done("mul_hold", lat);
    exp_q.push_back(model(2'd0, 6'd1, 6'd1));
    @(negedge clk);
    check("mul_hold gap done", int'(done), 0);
    check("mul_hold gap busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    compare_done("hold_next_add", done ? 1 : 0);
    @(negedge clk);

    // Reset in cycle 3 of a DIV
    @(negedge clk);
    op = 2'd3; a = 6'd18; b = 6'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    $display("reset mid-DIV -> busy=%0d done=%0d result=%0d hi=%0d dz=%0d",
             busy, done, result, hi, dz);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    check("abort hi", int'(hi), 0);
    check("abort dz", int'(dz), 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort no done", int'(seen), 0);
    do_op("post_reset_mul", model(2'd2, 6'd2, 6'd3));

    check("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
